decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- IF/ID pipeline register plus instruction decoder for the RV32I core.
- Sits between fetch and the register file: holds one fetched instruction and drives rs1/rs2 to the register file read ports.
- Produces immediate and control signals for execute over a valid/ready handshake.
- Detects load-use hazards and handles branch flushes.

Parameters:
- XLEN, 32, datapath width for pc and immediate.
- NOP_INSTR, 32'h0000_0013, instruction held in the IF/ID register after reset or flush (ADDI x0,x0,0).
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode can accept this cycle.
- if_instr  in  32  fetched instruction.
- if_pc  in  XLEN  pc of if_instr.
- flush  in  1  branch/jump redirect from execute; kills the held instruction.
- ex_ready  in  1  execute accepts the decoded instruction.
- ex_mem_read  in  1  instruction currently in execute is a load.
- ex_rd  in  5  destination of the instruction in execute.
- id_valid  out  1  decoded instruction valid for execute.
- rs1  out  5  register file read address 1 (instr[19:15]).
- rs2  out  5  register file read address 2 (instr[24:20]).
- id_rd  out  5  destination register (instr[11:7]).
- id_pc  out  XLEN  pc of held instruction.
- id_imm  out  XLEN  sign-extended immediate.
- id_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- id_alu_src  out  1  1 = operand B is id_imm.
- id_reg_write  out  1  writes rd; forced 0 when id_rd==0.
- id_mem_read  out  1  load.
- id_mem_write  out  1  store.
- id_branch  out  1  conditional branch.
- id_jump  out  1  JAL/JALR.
- stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- State: hold_valid, instr_q, pc_q, stall_cnt. All decode outputs are combinational from instr_q/pc_q.
- Reset (async, immediate):
  - hold_valid=0, instr_q=NOP_INSTR, pc_q=0, stall_cnt=0.
  - Hence id_valid=0, if_ready=1, id_reg_write=0.
- Hazard:
  - Condition: hazard = ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1) || (uses_rs2 && ex_rd==rs2)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL. uses_rs2: R-type, store, branch.
- Handshake:
  - id_valid = hold_valid && !hazard.
  - id_fire = id_valid && ex_ready.
  - if_ready = !hold_valid || id_fire.
  - if_fire = if_valid && if_ready.
- Update priority at each edge:
  1. flush: hold_valid<=0, instr_q<=NOP_INSTR. Any if_fire that cycle is dropped.
  2. if_fire: load instr_q/pc_q, hold_valid<=1. Zero-bubble back-to-back when id_fire and if_fire coincide.
  3. id_fire without if_fire: hold_valid<=0.
  4. Otherwise hold all state.
- Latency: instruction accepted at edge N is presented with id_valid=1 in the cycle after edge N (one cycle), absent hazard.
- Stall counter: stall_cnt increments by 1 each cycle hold_valid && hazard && !flush. Saturates at all-ones; no wrap.
- Immediates: I, S, B, U, J formats per RV32I. B/J have bit 0 = 0. All sign-extended from instr[31]. U-type is instr[31:12]<<12.
- ALU op mapping:
  - funct3/funct7[5] for OP.
  - OP-IMM uses funct7[5] only for SRAI.
  - Load/store/JAL/JALR/AUIPC use ADD; branch uses SUB; LUI uses PASS_B.
- Unknown opcode: all control outputs 0, id_alu_op=ADD, id_alu_src=0. Behaves as NOP.
- Reset mid-operation: held instruction discarded; no partial outputs.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - Extra output id_illegal (1 bit).
  - Asserted with id_valid when opcode is not one of the 9 RV32I classes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP) or instr[1:0]!=2'b11.
  - Control outputs are still forced to 0.
- When undefined: port absent; illegal instructions silently decode as NOP.

Test Plan:
- Reset release with if_valid=0 -> id_valid=0, if_ready=1, stall_cnt=0, id_reg_write=0.
- Feed ADDI x5,x1,-3 (0xFFD08293) at pc 0x100, ex_ready=1 -> next cycle: id_valid=1, rs1=1, id_rd=5, id_imm=0xFFFFFFFD, id_alu_op=0, id_alu_src=1, id_reg_write=1, id_pc=0x100.
- Back-to-back stream of 4 instructions with if_valid=1, ex_ready=1 -> one id_fire per cycle, no bubbles, pc order preserved.
- Held ADD x3,x2,x4 with ex_mem_read=1, ex_rd=4 for 2 cycles -> id_valid=0 and if_ready=0 for 2 cycles, stall_cnt=2; then id_valid=1.
- flush asserted while holding valid BEQ and if_valid=1 -> next cycle hold_valid=0, id_valid=0, incoming instruction dropped.
- With DECODE_ILLEGAL_TRAP_EN, feed 0x0000007F -> id_illegal=1, id_valid=1, id_reg_write=0, id_mem_write=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register and RV32I instruction decoder.
//
// Holds one fetched instruction and presents its decoded form to execute
// over a valid/ready handshake. Load-use hazards against the instruction in
// execute hold the instruction back. A flush from execute kills it.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_valid/if_ready         fetch handshake, carrying if_instr and if_pc
//   flush                     redirect from execute; kills the held instruction
//   ex_ready                  execute accepts the decoded instruction
//   ex_mem_read, ex_rd        load-in-execute info for hazard detection
//   id_valid                  decoded instruction valid for execute
//   rs1, rs2                  register file read addresses
//   id_rd, id_pc, id_imm      destination, pc, sign-extended immediate
//   id_alu_op, id_alu_src     ALU operation and operand-B select
//   id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  controls
//   stall_cnt                 saturating count of load-use stall cycles
//   id_illegal                (only with DECODE_ILLEGAL_TRAP_EN) unknown opcode
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
module decode_stage #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [31:0]            if_instr,
    input  logic [XLEN-1:0]        if_pc,
    input  logic                   flush,
    input  logic                   ex_ready,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    output logic                   id_valid,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             id_rd,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_imm,
    output logic [3:0]             id_alu_op,
    output logic                   id_alu_src,
    output logic                   id_reg_write,
    output logic                   id_mem_read,
    output logic                   id_mem_write,
    output logic                   id_branch,
    output logic                   id_jump,
    output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                   id_illegal
`endif
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    logic                   r_hold_valid;
    logic [31:0]            r_instr;
    logic [XLEN-1:0]        r_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_alt;
    logic [31:0] w_imm32;
    logic [3:0]  w_alu_op;
    logic        w_alu_src, w_rw, w_mr, w_mw, w_br, w_jp;
    logic        w_uses_rs1, w_uses_rs2, w_known;
    logic        w_hazard, w_id_valid, w_id_fire, w_if_ready, w_if_fire;

    // funct3 -> ALU op; alt selects SUB for 000 and SRA for 101.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_alt    = r_instr[30];

    always_comb begin
        w_imm32    = '0;
        w_alu_op   = ALU_ADD;
        w_alu_src  = 1'b0;
        w_rw       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_br       = 1'b0;
        w_jp       = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_known    = 1'b1;
        case (w_opcode)
            OPC_LUI: begin
                w_imm32 = {r_instr[31:12], 12'b0};
                w_alu_op = ALU_PASS_B; w_alu_src = 1'b1; w_rw = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm32 = {r_instr[31:12], 12'b0};
                w_alu_src = 1'b1; w_rw = 1'b1;
            end
            OPC_JAL: begin
                w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                           r_instr[20], r_instr[30:21], 1'b0};
                w_alu_src = 1'b1; w_rw = 1'b1; w_jp = 1'b1;
            end
            OPC_JALR: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
                w_alu_src = 1'b1; w_rw = 1'b1; w_jp = 1'b1; w_uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                           r_instr[30:25], r_instr[11:8], 1'b0};
                w_alu_op = ALU_SUB; w_br = 1'b1;
                w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
                w_alu_src = 1'b1; w_rw = 1'b1; w_mr = 1'b1; w_uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
                w_alu_src = 1'b1; w_mw = 1'b1;
                w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
                // Only shift-right immediates use bit 30; ADDI never becomes SUB.
                w_alu_op = f3_to_op(w_funct3, (w_funct3 == 3'b101) && w_alt);
                w_alu_src = 1'b1; w_rw = 1'b1; w_uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                w_alu_op = f3_to_op(w_funct3, w_alt);
                w_rw = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_hazard = ex_mem_read && (ex_rd != 5'd0) &&
                      ((w_uses_rs1 && ex_rd == r_instr[19:15]) ||
                       (w_uses_rs2 && ex_rd == r_instr[24:20]));

    assign w_id_valid = r_hold_valid && !w_hazard;
    assign w_id_fire  = w_id_valid && ex_ready;
    assign w_if_ready = !r_hold_valid || w_id_fire;
    assign w_if_fire  = if_valid && w_if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc         <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (flush) begin
                r_hold_valid <= 1'b0;
                r_instr      <= NOP_INSTR;
            end else if (w_if_fire) begin
                r_instr      <= if_instr;
                r_pc         <= if_pc;
                r_hold_valid <= 1'b1;
            end else if (w_id_fire) begin
                r_hold_valid <= 1'b0;
            end
            if (r_hold_valid && w_hazard && !flush && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign if_ready     = w_if_ready;
    assign id_valid     = w_id_valid;
    assign rs1          = r_instr[19:15];
    assign rs2          = r_instr[24:20];
    assign id_rd        = r_instr[11:7];
    assign id_pc        = r_pc;
    assign id_imm       = XLEN'($signed(w_imm32));
    assign id_alu_op    = w_alu_op;
    assign id_alu_src   = w_alu_src;
    assign id_reg_write = w_rw && (r_instr[11:7] != 5'd0);
    assign id_mem_read  = w_mr;
    assign id_mem_write = w_mw;
    assign id_branch    = w_br;
    assign id_jump      = w_jp;
    assign stall_cnt    = r_stall_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign id_illegal   = w_id_valid && !w_known;
`else
    logic w_unused_known;
    assign w_unused_known = w_known;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, flush, ex_ready, ex_mem_read, id_valid;
    logic [31:0] if_instr, if_pc, id_pc, id_imm;
    logic [4:0]  ex_rd, rs1, rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
    logic [15:0] stall_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        id_illegal;
`endif

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_ready(ex_ready), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_valid(id_valid), .rs1(rs1), .rs2(rs2), .id_rd(id_rd), .id_pc(id_pc),
        .id_imm(id_imm), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump),
        .stall_cnt(stall_cnt)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .id_illegal(id_illegal)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        bit          imm_chk;
        logic [3:0]  op;
        logic        src;
        logic [4:0]  ctl;   // {reg_write, mem_read, mem_write, branch, jump}
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   fire_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] imm, input bit imm_chk,
                                input logic [3:0] op, input logic src,
                                input logic [4:0] ctl, input logic ill);
        exp_t e;
        e.pc = pc; e.imm = imm; e.imm_chk = imm_chk;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.op = op; e.src = src; e.ctl = ctl; e.ill = ill;
        return e;
    endfunction

    // Monitor: every id_fire pops one expected decode and compares it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && ex_ready) begin
                fire_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fire actual_pc=0x%08h required=no_fire", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", id_pc, e.pc);
                    chk("rs1", 32'(rs1), 32'(e.rs1));
                    chk("rs2", 32'(rs2), 32'(e.rs2));
                    chk("rd", 32'(id_rd), 32'(e.rd));
                    if (e.imm_chk) chk("imm", id_imm, e.imm);
                    chk("alu_op", 32'(id_alu_op), 32'(e.op));
                    chk("alu_src", 32'(id_alu_src), 32'(e.src));
                    chk("ctl", 32'({id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump}),
                        32'(e.ctl));
`ifdef DECODE_ILLEGAL_TRAP_EN
                    chk("illegal", 32'(id_illegal), 32'(e.ill));
`endif
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one instruction and waits (bounded) until it is accepted.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input exp_t e, input bit push);
        int n;
        n = 0;
        if_valid = 1'b1; if_instr = ins; if_pc = pc;
        @(negedge clk);
        while (!if_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=if_ready_low required=accept pc=0x%08h", pc);
        end else if (push) begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 if_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; ex_ready = 1'b1; ex_mem_read = 1'b0; ex_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_reg_write", 32'(id_reg_write), 32'd0);
        idle(1);

        // ADDI x5,x1,-3: valid exactly one cycle after acceptance.
        issue(32'hFFD08293, 32'h100, mk(32'hFFD08293, 32'h100, 32'hFFFFFFFD, 1, 4'd0, 1, 5'b10000, 0), 1);
        @(negedge clk);
        chk("latency_id_valid", 32'(id_valid), 32'd1);
        idle(2);

        // Back-to-back burst: LUI, SW, SRAI, SUB.
        issue(32'h123453B7, 32'h200, mk(32'h123453B7, 32'h200, 32'h12345000, 1, 4'd10, 1, 5'b10000, 0), 1);
        issue(32'hFE612E23, 32'h204, mk(32'hFE612E23, 32'h204, 32'hFFFFFFFC, 1, 4'd0, 1, 5'b00100, 0), 1);
        issue(32'h4035D513, 32'h208, mk(32'h4035D513, 32'h208, 32'h00000403, 1, 4'd7, 1, 5'b10000, 0), 1);
        issue(32'h40A48433, 32'h20C, mk(32'h40A48433, 32'h20C, 32'h0, 0, 4'd1, 0, 5'b10000, 0), 1);
        idle(3);
        n = fire_cyc.size();
        if (n >= 4) chk("b2b_spacing", 32'(fire_cyc[n-1] - fire_cyc[n-4]), 32'd3);
        else chk("b2b_fire_count", 32'(n), 32'd5);

        // Load-use hazard: ADD x3,x2,x4 against a load to x4 for two cycles.
        ex_mem_read = 1'b1; ex_rd = 5'd4;
        issue(32'h004101B3, 32'h280, mk(32'h004101B3, 32'h280, 32'h0, 0, 4'd0, 0, 5'b10000, 0), 1);
        @(negedge clk);
        chk("hz1_id_valid", 32'(id_valid), 32'd0);
        chk("hz1_if_ready", 32'(if_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hz2_id_valid", 32'(id_valid), 32'd0);
        chk("hz2_if_ready", 32'(if_ready), 32'd0);
        chk("hz2_stall_cnt", 32'(stall_cnt), 32'd1);
        @(posedge clk);
        #1 ex_mem_read = 1'b0;
        @(negedge clk);
        chk("hz_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("hz_release_valid", 32'(id_valid), 32'd1);
        idle(2);

        // Flush kills a held BEQ and drops the incoming JAL.
        ex_ready = 1'b0;
        issue(32'h00208463, 32'h300, mk(32'h00208463, 32'h300, 32'h8, 1, 4'd1, 0, 5'b00010, 0), 0);
        @(negedge clk);
        chk("flush_pre_valid", 32'(id_valid), 32'd1);
        @(posedge clk);
        #1 flush = 1'b1; if_valid = 1'b1; if_instr = 32'h001000EF; if_pc = 32'h304;
        @(posedge clk);
        #1 flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        chk("flush_if_ready", 32'(if_ready), 32'd1);
        chk("flush_nop_rd", 32'(id_rd), 32'd0);
        idle(1);

        // Asynchronous reset while an instruction is held.
        ex_ready = 1'b0;
        issue(32'hFFD08293, 32'h500, mk(32'hFFD08293, 32'h500, 32'h0, 0, 4'd0, 1, 5'b10000, 0), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_id_valid", 32'(id_valid), 32'd0);
        chk("arst_if_ready", 32'(if_ready), 32'd1);
        chk("arst_pc", id_pc, 32'h0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; ex_ready = 1'b1;
        idle(1);

        // Remaining formats: JAL (imm bit 11), AUIPC, LW x0, unknown, BEQ.
        issue(32'h001000EF, 32'h400, mk(32'h001000EF, 32'h400, 32'h00000800, 1, 4'd0, 1, 5'b10001, 0), 1);
        issue(32'hFFFFF217, 32'h404, mk(32'hFFFFF217, 32'h404, 32'hFFFFF000, 1, 4'd0, 1, 5'b10000, 0), 1);
        issue(32'h0000A003, 32'h408, mk(32'h0000A003, 32'h408, 32'h0, 1, 4'd0, 1, 5'b01000, 0), 1);
        issue(32'h0000007F, 32'h40C, mk(32'h0000007F, 32'h40C, 32'h0, 0, 4'd0, 0, 5'b00000, 1), 1);
        issue(32'h00208463, 32'h410, mk(32'h00208463, 32'h410, 32'h8, 1, 4'd1, 0, 5'b00010, 0), 1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        idle(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
